serial_in_rx: RTL and testbench
===============================

Name: serial_in_rx

Overview:
UART receiver, 8N1 (1 start bit, 8 data bits LSB-first, 1 stop bit, no parity).
- Oversamples the asynchronous rxd line with the system clock and recovers bytes.
- Presents each byte on data with a one-cycle done strobe and a sticky rxready flag.
- Sits on the simulation/host side of the board TXD line, monitoring characters emitted by the CPU system's serial transmitter.

Parameters:
CLKS_PER_BIT, 434, m_clock cycles per serial bit; must equal the transmitter's bit period; legal range 4..65535.

Ports:
m_clock  input  1  system clock; all logic on rising edge
p_reset  input  1  reset, synchronous, active-high
rxd  input  1  serial line, idle high, asynchronous to m_clock
port_read  input  1  consumer acknowledge; high for one cycle clears rxready
rxready  output  1  sticky "byte available" flag
data  output  8  last correctly received byte
done  output  1  one-cycle pulse when a byte is accepted

Behaviour:
- Reset (p_reset high at a clock edge): state=IDLE, data=0x00, done=0, rxready=0, counters=0, synchronizer flops=1. Reset mid-frame aborts the frame with no done.
- rxd passes through a 2-flop synchronizer before any use; latency 2 cycles.
- FSM states:
  - IDLE: wait for synchronized rxd=0, then go to START with bit counter cleared and clock counter=0.
  - START: at count CLKS_PER_BIT/2 (integer division), sample rxd.
    - Low: valid start; go to DATA, clock counter=0.
    - High: glitch; return to IDLE, no output change.
  - DATA: every CLKS_PER_BIT cycles (mid-bit), shift the sampled bit into a shift register at the MSB end, LSB arrives first. After the 8th sample, go to STOP.
  - STOP: after CLKS_PER_BIT cycles (mid stop bit), sample rxd.
    - High: on the next edge data<=shift register, done=1 for exactly one cycle, rxready<=1; go to IDLE.
    - Low (framing error): discard the byte, no done, rxready and data unchanged; go to WAIT_IDLE.
  - WAIT_IDLE: stay until synchronized rxd=1, then IDLE.
- data changes only on the edge that raises done and is stable while done=1 and until the next accepted byte.
- Back-to-back frames: returning to IDLE at mid stop bit allows a start bit immediately after the stop bit.
- rxready:
  - Set by byte acceptance; cleared by port_read=1.
  - Simultaneous set and port_read: set wins.
- Overrun: a new byte while rxready=1 overwrites data; rxready stays 1; no error flag.
- port_read while rxready=0: no effect.
- Worst-case acceptance latency from the stop-bit mid-point: 1 cycle; from the rxd falling edge: about 9.5*CLKS_PER_BIT+3 cycles.

Test Plan:
- CLKS_PER_BIT=8, reset 3 cycles, then frame 0x41 (bits 1,0,0,0,0,0,1,0 after start) -> exactly one done pulse, data=0x41 during the pulse, rxready=1 afterwards, rxready=0 the cycle after a port_read pulse.
- Frames 0x00, then 0xFF, then 0xA5 back-to-back with no idle gap -> three done pulses, data 0x00, 0xFF, 0xA5 in order, rxready stays 1 without port_read.
- rxd low for 2 cycles, then high (glitch shorter than a half bit) -> no done, FSM back in IDLE; next valid frame 0x5A received correctly.
- Frame 0x33 with stop bit driven low, then line held low 20 cycles, then high -> no done, data keeps its previous value; following frame 0x7E accepted.
- p_reset asserted during data bit 4 of a frame -> data=0, rxready=0, done never pulses for that frame; next full frame 0xC3 received.
- port_read held high on the same cycle done pulses for 0x12 -> rxready=1 after that cycle.

Source files
------------

// File: rtl/serial_in_rx.sv
// 8N1 UART receiver: oversamples the rxd line on m_clock and recovers bytes.
// Each accepted byte produces a one-cycle done strobe and sets a sticky rxready flag.
module serial_in_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       m_clock,
  input  logic       p_reset,
  input  logic       rxd,
  input  logic       port_read,
  output logic       rxready,
  output logic [7:0] data,
  output logic       done
);

  localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t      state_q;
  logic        rx_meta_q, rx_sync_q;
  logic [15:0] clk_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        done_q;
  logic        rxready_q;
  logic        accept;
  logic        rxready_d;

  // Good stop bit seen at its mid-point: the byte is accepted on this edge.
  assign accept = (state_q == STOP) && (clk_cnt_q == FULL_CNT) && rx_sync_q;

  // The acceptance event spans the done cycle, so a read during done
  // cannot cancel the flag for the byte being delivered.
  assign rxready_d = accept | done_q | (rxready_q & ~port_read);

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      rxready_q <= 1'b0;
    end else begin
      rx_meta_q <= rxd;
      rx_sync_q <= rx_meta_q;
      done_q    <= 1'b0;
      rxready_q <= rxready_d;
      case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          bit_cnt_q <= '0;
          if (!rx_sync_q) state_q <= START;
        end
        START: begin
          if (clk_cnt_q == HALF_CNT) begin
            clk_cnt_q <= '0;
            state_q   <= rx_sync_q ? IDLE : DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (clk_cnt_q == FULL_CNT) begin
            clk_cnt_q <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (clk_cnt_q == FULL_CNT) begin
            clk_cnt_q <= '0;
            if (accept) begin
              data_q  <= shift_q;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= WAIT_IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
        WAIT_IDLE: begin
          if (rx_sync_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data    = data_q;
  assign done    = done_q;
  assign rxready = rxready_q;

endmodule

// File: tb/tb_serial_in_rx.sv
// Bench for serial_in_rx: drives 8N1 frames and compares received bytes
// against a queue of bytes expected from the frames sent.
module tb_serial_in_rx;

  localparam int CPB = 8;

  logic       m_clock = 1'b0;
  logic       p_reset;
  logic       rxd;
  logic       port_read;
  logic       rxready;
  logic [7:0] data;
  logic       done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_good;

  serial_in_rx #(.CLKS_PER_BIT(CPB)) dut (
    .m_clock  (m_clock),
    .p_reset  (p_reset),
    .rxd      (rxd),
    .port_read(port_read),
    .rxready  (rxready),
    .data     (data),
    .done     (done)
  );

  always #5 m_clock = ~m_clock;

  // Record every byte delivered with a done strobe.
  always @(negedge m_clock) if (done === 1'b1) rx_q.push_back(data);

  task automatic idle(input int n);
    repeat (n) @(negedge m_clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (CPB) @(negedge m_clock);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge m_clock);
    end
    rxd = stop;
    repeat (CPB) @(negedge m_clock);
    rxd = 1'b1;
  endtask

  // Compare everything recorded since the last clear against exp_q.
  task automatic compare_rx(input string name);
    int got;
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s count: got %0d bytes, expected %0d", name, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < rx_q.size()) ? int'(rx_q[i]) : -1;
      checks++;
      if (got != int'(exp_q[i])) begin
        failures++;
        $display("FAIL %s byte%0d: got %0d, expected 0x%02h", name, i, got, exp_q[i]);
      end
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset;
    p_reset = 1'b1; rxd = 1'b1; port_read = 1'b0;
    idle(3);
    p_reset = 1'b0;
    idle(2);
    checks++;
    if (data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h, expected 00", data); end
    checks++;
    if (rxready !== 1'b0) begin failures++; $display("FAIL reset_rxready: got %b, expected 0", rxready); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b, expected 0", done); end
    rx_q.delete();
  endtask

  task automatic test_single;
    exp_q.push_back(8'h41);
    send_frame(8'h41, 1'b1);
    idle(4);
    compare_rx("single");
    last_good = 8'h41;
    checks++;
    if (rxready !== 1'b1) begin failures++; $display("FAIL single_rxready: got %b, expected 1", rxready); end
    port_read = 1'b1;
    idle(1);
    port_read = 1'b0;
    checks++;
    if (rxready !== 1'b0) begin failures++; $display("FAIL single_read_clear: got %b, expected 0", rxready); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] seq [3];
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(seq[i]);
      send_frame(seq[i], 1'b1);
    end
    idle(4);
    compare_rx("b2b");
    last_good = 8'hA5;
    checks++;
    if (rxready !== 1'b1) begin failures++; $display("FAIL b2b_rxready: got %b, expected 1", rxready); end
  endtask

  task automatic test_glitch;
    rxd = 1'b0;
    idle(2);
    rxd = 1'b1;
    idle(3 * CPB);
    compare_rx("glitch");
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(4);
    compare_rx("after_glitch");
    last_good = 8'h5A;
  endtask

  task automatic test_framing;
    send_frame(8'h33, 1'b0);
    rxd = 1'b0;
    idle(20);
    rxd = 1'b1;
    idle(2 * CPB);
    compare_rx("framing");
    checks++;
    if (data !== last_good) begin failures++; $display("FAIL framing_data: got %h, expected %h", data, last_good); end
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    idle(4);
    compare_rx("after_framing");
    last_good = 8'h7E;
  endtask

  task automatic test_reset_midframe;
    // 0xF5 keeps the line high from data bit 4 on, so the aborted tail
    // cannot look like a new start bit.
    fork
      send_frame(8'hF5, 1'b1);
      begin
        idle(CPB * 5 + 2);
        p_reset = 1'b1;
        idle(3);
        p_reset = 1'b0;
      end
    join
    idle(2 * CPB);
    compare_rx("midframe_reset");
    checks++;
    if (data !== 8'h00) begin failures++; $display("FAIL midreset_data: got %h, expected 00", data); end
    checks++;
    if (rxready !== 1'b0) begin failures++; $display("FAIL midreset_rxready: got %b, expected 0", rxready); end
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    idle(4);
    compare_rx("after_midreset");
    last_good = 8'hC3;
  endtask

  task automatic test_read_collision;
    bit seen = 0;
    port_read = 1'b1;
    idle(1);
    port_read = 1'b0;
    exp_q.push_back(8'h12);
    fork
      send_frame(8'h12, 1'b1);
      begin
        for (int i = 0; i < 20 * CPB && !seen; i++) begin
          @(negedge m_clock);
          if (done === 1'b1) begin
            seen = 1;
            port_read = 1'b1;
            @(negedge m_clock);
            port_read = 1'b0;
          end
        end
      end
    join
    idle(2);
    checks++;
    if (!seen) begin failures++; $display("FAIL collision_done: no done within %0d cycles", 20 * CPB); end
    checks++;
    if (rxready !== 1'b1) begin failures++; $display("FAIL collision_rxready: got %b, expected 1", rxready); end
    compare_rx("collision");
  endtask

  task automatic test_random;
    logic [7:0] b;
    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      idle($urandom_range(0, 3));
    end
    idle(4);
    compare_rx("random");
  endtask

  initial begin
    p_reset = 1'b1; rxd = 1'b1; port_read = 1'b0; last_good = 8'h00;
    @(negedge m_clock);
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_framing;
    test_reset_midframe;
    test_read_collision;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
